// File: rtl/matmul_seq.sv
// Sequential fixed-point matrix multiplier O = A x B using one MAC per clock, row-major output order.
// Optional saturation of each result to S bits is enabled by defining MATMUL_SAT_EN.
module matmul_seq #(
    parameter int S    = 32,
    parameter int FRAC = 16,
    parameter int H    = 2,
    parameter int C    = 2,
    parameter int W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [H*C*S-1:0] a,
    input  logic [C*W*S-1:0] b,
    output logic [H*W*S-1:0] o,
    output logic             busy,
    output logic             done
);

    localparam int PW   = 2 * S;
    localparam int ACCW = 2 * S + $clog2(C) + 1;
    localparam int RB   = (H > 1) ? $clog2(H) : 1;
    localparam int KB   = (C > 1) ? $clog2(C) : 1;
    localparam int CB   = (W > 1) ? $clog2(W) : 1;

    localparam logic [RB-1:0] R_LAST = RB'(H - 1);
    localparam logic [KB-1:0] K_LAST = KB'(C - 1);
    localparam logic [CB-1:0] C_LAST = CB'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        WRITE,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [S-1:0]    r_a [H][C];
    logic signed [S-1:0]    r_b [C][W];
    logic signed [S-1:0]    r_o [H][W];
    logic        [RB-1:0]   r_r;
    logic        [KB-1:0]   r_k;
    logic        [CB-1:0]   r_c;
    logic signed [ACCW-1:0] r_acc;

    logic signed [PW-1:0]   w_a_ext;
    logic signed [PW-1:0]   w_b_ext;
    logic signed [PW-1:0]   w_prod;
    logic signed [S-1:0]    w_res;
    logic                   w_last_elem;

    assign w_a_ext     = PW'(r_a[r_r][r_k]);
    assign w_b_ext     = PW'(r_b[r_k][r_c]);
    assign w_prod      = w_a_ext * w_b_ext;
    assign w_last_elem = (r_r == R_LAST) && (r_c == C_LAST);

`ifdef MATMUL_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'({1'b0, {(S-1){1'b1}}});
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACCW-1:0] w_shift;

    assign w_shift = r_acc >>> FRAC;

    always_comb begin
        if (w_shift > SAT_MAX)
            w_res = SAT_MAX[S-1:0];
        else if (w_shift < SAT_MIN)
            w_res = SAT_MIN[S-1:0];
        else
            w_res = w_shift[S-1:0];
    end
`else
    // Low S bits of (acc >>> FRAC) are exactly this slice of the accumulator.
    assign w_res = r_acc[FRAC +: S];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = MAC;
            MAC:     if (r_k == K_LAST) w_next = WRITE;
            WRITE:   w_next = w_last_elem ? DONE : MAC;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r   <= '0;
            r_k   <= '0;
            r_c   <= '0;
            r_acc <= '0;
            for (int unsigned i = 0; i < H; i++)
                for (int unsigned j = 0; j < C; j++)
                    r_a[i][j] <= '0;
            for (int unsigned i = 0; i < C; i++)
                for (int unsigned j = 0; j < W; j++)
                    r_b[i][j] <= '0;
            for (int unsigned i = 0; i < H; i++)
                for (int unsigned j = 0; j < W; j++)
                    r_o[i][j] <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_r   <= '0;
                        r_k   <= '0;
                        r_c   <= '0;
                        r_acc <= '0;
                        for (int unsigned i = 0; i < H; i++)
                            for (int unsigned j = 0; j < C; j++)
                                r_a[i][j] <= a[(i*C+j)*S +: S];
                        for (int unsigned i = 0; i < C; i++)
                            for (int unsigned j = 0; j < W; j++)
                                r_b[i][j] <= b[(i*W+j)*S +: S];
                    end
                end
                MAC: begin
                    r_acc <= r_acc + ACCW'(w_prod);
                    if (r_k != K_LAST)
                        r_k <= r_k + KB'(1);
                end
                WRITE: begin
                    r_o[r_r][r_c] <= w_res;
                    r_acc         <= '0;
                    r_k           <= '0;
                    if (r_c == C_LAST) begin
                        r_c <= '0;
                        r_r <= (r_r == R_LAST) ? '0 : r_r + RB'(1);
                    end else begin
                        r_c <= r_c + CB'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gr = 0; gr < H; gr++) begin : g_row
        for (genvar gc = 0; gc < W; gc++) begin : g_col
            assign o[(gr*W+gc)*S +: S] = r_o[gr][gc];
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_matmul_seq.sv
// Directed self-checking bench for matmul_seq: default 2x2x2 instance plus a 1x3x2 non-square instance.
module tb_matmul_seq;

    localparam logic [31:0] Q1 = 32'h0001_0000;
    localparam logic [31:0] Q2 = 32'h0002_0000;
    localparam logic [31:0] Q3 = 32'h0003_0000;
    localparam logic [31:0] Q4 = 32'h0004_0000;
`ifdef MATMUL_SAT_EN
    localparam logic [31:0] OVF_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_EXP = 32'h0002_0000;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] o;
    logic         busy;
    logic         done;

    logic         start2;
    logic [95:0]  a2;
    logic [191:0] b2;
    logic [63:0]  o2;
    logic         busy2;
    logic         done2;

    int n_vec = 0;
    int n_bad = 0;

    logic [127:0] sb_q  [$];
    logic [63:0]  sb2_q [$];

    always #5 clk = ~clk;

    matmul_seq #(.S(32), .FRAC(16), .H(2), .C(2), .W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .o(o), .busy(busy), .done(done)
    );

    matmul_seq #(.S(32), .FRAC(16), .H(1), .C(3), .W(2)) u_dut_ns (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .o(o2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] m4(input logic [31:0] e0, input logic [31:0] e1,
                                        input logic [31:0] e2, input logic [31:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One product on the 2x2x2 instance; optionally re-pulses start with other operands mid-run.
    task automatic run(input string tag, input logic [127:0] av, input logic [127:0] bv,
                       input logic [127:0] exp, input int dist_cyc,
                       input logic [127:0] ad, input logic [127:0] bd);
        logic [127:0] e;
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        sb_q.push_back(exp);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            if (n == dist_cyc) begin
                a     = ad;
                b     = bd;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) lat = n;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd12);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd12);
        e = sb_q.pop_front();
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_o%0d", tag, i), 64'(o[i*32 +: 32]), 64'(e[i*32 +: 32]));
        tick();
        chk({tag, "_done_fall"}, 64'(done), 64'd0);
        chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
        tick();
        tick();
        chk({tag, "_no_queue"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] e2;
        int lat2;
        int done_seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        tick();
        tick();
        chk("rst_o", o[63:0], 64'd0);
        chk("rst_o_hi", o[127:64], 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_o_ns", o2, 64'd0);
        rst_n = 1'b1;
        tick();

        run("five", {4{32'h0005_0000}}, {4{32'h0005_0000}}, {4{32'h0032_0000}}, 0, '0, '0);
        run("ident", m4(Q1, 0, 0, Q1), m4(Q1, Q2, Q3, Q4), m4(Q1, Q2, Q3, Q4), 0, '0, '0);
        run("swap", m4(Q1, Q2, Q3, Q4), m4(Q1, 0, 0, Q1), m4(Q1, Q2, Q3, Q4), 0, '0, '0);
        run("signed", {4{32'hFFFE_8000}}, {4{32'h0002_0000}}, {4{32'hFFFA_0000}}, 0, '0, '0);
        run("ovf", {4{32'h7FFF_0000}}, {4{32'h7FFF_0000}}, {4{OVF_EXP}}, 0, '0, '0);
        run("ctrl", {4{Q2}}, {4{Q3}}, {4{32'h000C_0000}}, 5, m4(Q1, 0, 0, Q1), m4(Q1, Q2, Q3, Q4));

        // Abort a run with reset at cycle 7; done must never pulse afterwards.
        a     = {4{32'h0005_0000}};
        b     = {4{32'h0005_0000}};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_o_lo", o[63:0], 64'd0);
        chk("abort_o_hi", o[127:64], 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);

        run("post_rst", m4(Q1, Q2, Q3, Q4), m4(Q1, 0, 0, Q1), m4(Q1, Q2, Q3, Q4), 0, '0, '0);

        // Non-square 1x3 by 3x2: A={1,2,3}, B={{1,0},{0,1},{1,1}} -> {4,5}.
        sb2_q.push_back({32'h0005_0000, 32'h0004_0000});
        a2     = {Q3, Q2, Q1};
        b2     = {Q1, Q1, Q1, 32'h0, 32'h0, Q1};
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        a2     = '1;
        b2     = '1;
        lat2   = 0;
        for (int n = 1; n <= 30 && lat2 == 0; n++) begin
            tick();
            if (done2 === 1'b1) lat2 = n;
        end
        chk("ns_latency", 64'(lat2), 64'd8);
        e2 = sb2_q.pop_front();
        chk("ns_o0", 64'(o2[31:0]), 64'(e2[31:0]));
        chk("ns_o1", 64'(o2[63:32]), 64'(e2[63:32]));
        tick();
        chk("ns_busy_fall", 64'(busy2), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_seq.md
# matmul_seq

Sequential fixed-point matrix multiplier: computes O = A × B for a parametrised H×C by C×W product using a single multiply-accumulate datapath, one product per clock. It is the parametrised successor to the combinational-style `matmul` block in the neural-net datapath. It adds non-square shapes, a configurable Q-format, a busy/done handshake with operand latching, and optional saturation. Layer controllers drive it with a one-cycle `start` pulse and wait for the `done` pulse.

## Interface

Parameters:

- S, 32, element width in bits (signed two's complement)
- FRAC, 16, fractional bits of every element (Q(S-FRAC).FRAC)
- H, 2, rows of A and O
- C, 2, columns of A and rows of B (inner dimension, ≥1)
- W, 2, columns of B and O

Ports (one clock; reset is asynchronous and active-low):

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a product; sampled only in IDLE
- a  in  H*C*S  matrix A; element (r,k) at bits [(r*C+k)*S +: S]
- b  in  C*W*S  matrix B; element (k,c) at bits [(k*W+c)*S +: S]
- o  out  H*W*S  matrix O; element (r,c) at bits [(r*W+c)*S +: S]
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse; all of `o` is valid while high

## Operation

- States: IDLE, MAC, WRITE, DONE.
- IDLE:
  - On `start`=1, latch `a` and `b` into internal operand registers.
  - Clear the accumulator and the indices r, k, c.
  - Go to MAC.
- MAC:
  - Compute acc += A[r][k] × B[k][c]. The product is a signed full 2S-bit value.
  - The accumulator is 2S+clog2(C)+1 bits, so it never overflows internally.
  - If k==C-1, go to WRITE. Otherwise k++.
- WRITE:
  - Compute res = acc >>> FRAC. This is an arithmetic shift that truncates toward −∞.
  - Store res to O[r][c], narrowed to S bits as described in Configuration.
  - Clear acc and k.
  - If (r,c)==(H-1,W-1), go to DONE.
  - Otherwise advance c, and on column wrap reset c to 0 and increment r. Then go to MAC.
- DONE: go to IDLE unconditionally.
- Element order is row-major. `o` is updated one element at a time. Elements not yet written in the current run keep their previous values.
- After latching, the operand inputs are don't-care. `a` and `b` may change freely.
- `start` while busy (MAC, WRITE or DONE) is ignored. It is not queued.
- Reset values: state IDLE, `o`=0, `busy`=0, `done`=0, accumulator and indices 0.
- Reset asserted mid-operation aborts immediately to reset values. No partial `done` is produced.

## Timing

- Let T0 be the rising edge that samples `start`=1 in IDLE.
- `busy` rises after T0.
- Each output element takes C MAC cycles plus 1 WRITE cycle.
- The last element is committed at edge T0+H·W·(C+1). At that same edge the state becomes DONE, so `done`=1 for exactly one cycle.
- At the following edge, `done` and `busy` fall (IDLE).
- The earliest next `start` is sampled at edge T0+H·W·(C+1)+2.
- Reference latency for the default 2×2×2 configuration: `done` is high 12 cycles after T0.
- `done` and `busy` are registered outputs, decoded from the state register.

## Configuration

- Macro: `MATMUL_SAT_EN`.
- Defined: res is saturated to S bits, clamping to [−2^(S−1), 2^(S−1)−1].
- Not defined: the low S bits of res are stored (wrap-around). No saturation logic is built.

## Test plan

- Defaults (S=32, FRAC=16, H=C=W=2). All elements of `a` and `b` are 0x00050000 (5.0), start pulse → every element of `o` = 0x00320000 (50.0). `done` is high 12 cycles after the start edge for exactly one cycle, `busy` is high during cycles 1–12, and nothing is queued.
- A = identity (0x00010000 on the diagonal, 0 elsewhere), B = {1.0, 2.0, 3.0, 4.0} → `o` equals B exactly. Then repeat with A and B swapped.
- Signed case: A = all 0xFFFE8000 (−1.5), B = all 0x00020000 (2.0) → each O element is 0xFFFA0000 (−6.0).
- Overflow: A = B = all 0x7FFF0000. With `MATMUL_SAT_EN` → each O element is 0x7FFFFFFF. Without it → each O element is 0x00020000.
- Control: pulse `start` again at cycle 5 with different operands → ignored, and the results match the first operands. Deassert `rst_n` at cycle 7 → `o`=0, `busy`=0, and `done` never pulses. A fresh start after reset completes normally.
- Non-square shape H=1, C=3, W=2 with A = {1, 2, 3} and B = {{1, 0}, {0, 1}, {1, 1}} (Q16.16) → `o` = {4.0, 5.0}, and `done` is high 8 cycles after the start edge.
